// File: rtl/seg7_arbiter.sv
// rtl/seg7_arbiter.sv - three-requester round-robin arbiter for a shared 7-segment display driver
// Owner writes are forwarded to disp_data/disp_cs; long holds are broken only when someone else waits.
module seg7_arbiter #(
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  wr,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic        busy,
    output logic [31:0] disp_data,
    output logic        disp_cs
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_OWN     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [15:0] HOLD_MAX = 16'(MAX_HOLD);

    logic [1:0]  r_state;
    logic [1:0]  r_last;
    logic [15:0] r_hold;
    logic [2:0]  r_gnt;
    logic [1:0]  r_owner;
    logic        r_busy;
    logic [31:0] r_disp_data;
    logic        r_disp_cs;

    logic [1:0]  w_first;
    logic [1:0]  w_second;
    logic [1:0]  w_third;
    logic [1:0]  w_winner;
    logic [2:0]  w_owner_mask;
    logic        w_own_req;
    logic        w_other_wait;
    logic        w_hold_max;
    logic        w_release;
    logic        w_accept;
    logic [31:0] w_wr_data;

    function automatic logic [1:0] next3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order starts just after the previous owner so nobody can be starved.
    always_comb begin
        w_first  = next3(r_last);
        w_second = next3(w_first);
        w_third  = next3(w_second);
        if (req[w_first])
            w_winner = w_first;
        else if (req[w_second])
            w_winner = w_second;
        else
            w_winner = w_third;
    end

    always_comb begin
        w_owner_mask = 3'b001 << r_owner;
        w_own_req    = |(req & w_owner_mask);
        w_other_wait = |(req & ~w_owner_mask);
        w_hold_max   = (r_hold == HOLD_MAX);
        w_release    = !w_own_req || (w_hold_max && w_other_wait);
        w_accept     = |(r_gnt & wr);
        case (r_owner)
            2'd1:    w_wr_data = data1;
            2'd2:    w_wr_data = data2;
            default: w_wr_data = data0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 2'd2;
            r_hold      <= 16'd0;
            r_gnt       <= 3'b000;
            r_owner     <= 2'd0;
            r_busy      <= 1'b0;
            r_disp_data <= 32'd0;
            r_disp_cs   <= 1'b0;
        end else begin
            // gnt is only non-zero in OWN, so this also covers the edge that leaves OWN.
            r_disp_cs <= w_accept;
            if (w_accept)
                r_disp_data <= w_wr_data;

            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state <= S_OWN;
                        r_gnt   <= 3'b001 << w_winner;
                        r_owner <= w_winner;
                        r_hold  <= 16'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        r_state <= S_RELEASE;
                        r_gnt   <= 3'b000;
                        r_last  <= r_owner;
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + 16'd1;
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 3'b000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign disp_data = r_disp_data;
    assign disp_cs   = r_disp_cs;

endmodule
